pc_fetch_unit: RTL and testbench

Program-counter register plus instruction-fetch sequencer, sitting directly downstream of the 16-bit 4:1 PC-source mux. The unit latches the mux output into PC on LD_PC and returns PC+1 to the mux's Din0 leg. On request, it fetches the word at PC from memory into IR through a req/ready handshake with a wait-state timeout.

---
 rtl/lc3_fetch_pkg.sv | 19 +
 rtl/pc_fetch_unit_if.sv | 24 ++
 rtl/fetch_timer.sv | 31 +++
 rtl/pc_fetch_unit.sv | 119 +++++++++++
 tb/tb_pc_fetch_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/lc3_fetch_pkg.sv
// Shared types and constants for the LC-3 program-counter / instruction-fetch slice.
package lc3_fetch_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 16'h3000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ERR  = 2'd2
  } fetch_state_t;

  // Successor address, modulo 2^WORD_W.
  function automatic logic [WORD_W-1:0] next_word_addr(input logic [WORD_W-1:0] addr);
    return addr + {{(WORD_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Memory read handshake between the fetch sequencer (master) and instruction memory (slave).
interface pc_fetch_unit_if;
  import lc3_fetch_pkg::*;

  logic              mem_req;
  logic [WORD_W-1:0] mem_addr;
  logic              mem_rdy;
  logic [WORD_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdy,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdy,
    output mem_rdata
  );

endinterface

// File: rtl/fetch_timer.sv
// Saturating wait-state counter; flags the last permitted cycle of a memory request.
module fetch_timer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam bit TIMEOUT_ON = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W      = TIMEOUT_ON ? (($clog2(TIMEOUT_CYCLES + 1) > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_ON ? (TIMEOUT_CYCLES - 1) : 0);

  logic [CNT_W-1:0] count;

  // Holds at all-ones rather than wrapping so a long stall can never look fresh.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  assign expired = TIMEOUT_ON && enable && (count == LAST_COUNT);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter plus single-word instruction fetch sequencer with wait-state timeout.
module pc_fetch_unit
  import lc3_fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter int                TIMEOUT_CYCLES = 15
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [WORD_W-1:0] pc_next,
  input  logic              LD_PC,
  input  logic              fetch_start,
  pc_fetch_unit_if.master   mem,
  output logic [WORD_W-1:0] PC,
  output logic [WORD_W-1:0] pc_plus1,
  output logic [WORD_W-1:0] IR,
  output logic              fetch_busy,
  output logic              fetch_done,
  output logic              timeout_err
);

  fetch_state_t state;
  fetch_state_t next_state;

  logic launch_fetch;
  logic capture_ir;
  logic raise_err;
  logic clear_err;
  logic wait_enable;
  logic wait_expired;

  fetch_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .clear  (launch_fetch),
    .enable (wait_enable),
    .expired(wait_expired)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A ready response on the final wait cycle takes priority over the timeout.
  always_comb begin
    next_state   = state;
    launch_fetch = 1'b0;
    capture_ir   = 1'b0;
    raise_err    = 1'b0;
    clear_err    = 1'b0;
    wait_enable  = 1'b0;
    unique case (state)
      IDLE: begin
        if (fetch_start) begin
          next_state   = REQ;
          launch_fetch = 1'b1;
        end
      end
      REQ: begin
        if (mem.mem_rdy) begin
          next_state = IDLE;
          capture_ir = 1'b1;
        end else begin
          wait_enable = 1'b1;
          if (wait_expired) begin
            next_state = ERR;
            raise_err  = 1'b1;
          end
        end
      end
      ERR: begin
        if (fetch_start) begin
          next_state   = REQ;
          launch_fetch = 1'b1;
          clear_err    = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // PC loads independently of the fetch; mem_addr snapshots the pre-load PC.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      PC           <= RESET_PC;
      IR           <= '0;
      mem.mem_addr <= '0;
      fetch_done   <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if (LD_PC) begin
        PC <= pc_next;
      end
      if (launch_fetch) begin
        mem.mem_addr <= PC;
      end
      if (capture_ir) begin
        IR <= mem.mem_rdata;
      end
      fetch_done <= capture_ir;
      if (raise_err) begin
        timeout_err <= 1'b1;
      end else if (clear_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

  assign pc_plus1    = next_word_addr(PC);
  assign mem.mem_req = (state == REQ);
  assign fetch_busy  = (state == REQ);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit: reset, PC wrap, fetch latency, timeout and collisions.
module tb_pc_fetch_unit;

  logic        Clk;
  logic        Reset_n;
  logic [15:0] pc_next;
  logic        LD_PC;
  logic        fetch_start;
  logic [15:0] PC;
  logic [15:0] pc_plus1;
  logic [15:0] IR;
  logic        fetch_busy;
  logic        fetch_done;
  logic        timeout_err;

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  pc_fetch_unit_if mem_bus ();

  pc_fetch_unit #(
    .RESET_PC      (16'h3000),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .pc_next    (pc_next),
    .LD_PC      (LD_PC),
    .fetch_start(fetch_start),
    .mem        (mem_bus),
    .PC         (PC),
    .pc_plus1   (pc_plus1),
    .IR         (IR),
    .fetch_busy (fetch_busy),
    .fetch_done (fetch_done),
    .timeout_err(timeout_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic stepClock(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic [15:0] nxt, input logic start,
                               input logic rdy, input logic [15:0] rdata);
    LD_PC             = ld;
    pc_next           = nxt;
    fetch_start       = start;
    mem_bus.mem_rdy   = rdy;
    mem_bus.mem_rdata = rdata;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset_n = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);

    // Asynchronous reset asserted between edges must take effect at once.
    #2 Reset_n = 1'b0;
    #1;
    checkOutput("rst_pc",       PC,                   16'h3000);
    checkOutput("rst_ir",       IR,                   16'h0000);
    checkOutput("rst_req",      {15'd0, mem_bus.mem_req}, 16'd0);
    checkOutput("rst_addr",     mem_bus.mem_addr,     16'h0000);
    checkOutput("rst_done",     {15'd0, fetch_done},  16'd0);
    checkOutput("rst_err",      {15'd0, timeout_err}, 16'd0);
    checkOutput("rst_plus1",    pc_plus1,             16'h3001);
    stepClock(2);
    checkOutput("rst_hold_pc",  PC,                   16'h3000);
    Reset_n = 1'b1;
    stepClock(1);
    checkOutput("post_rst_pc",  PC,                   16'h3000);
    checkOutput("post_rst_busy", {15'd0, fetch_busy}, 16'd0);

    // PC load and wrap through the incrementer.
    applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000);
    stepClock(1);
    checkOutput("ld_ffff",      PC,                   16'hFFFF);
    checkOutput("plus1_wrap",   pc_plus1,             16'h0000);
    applyStimulus(1'b1, pc_plus1, 1'b0, 1'b0, 16'h0000);
    stepClock(1);
    checkOutput("pc_wrapped",   PC,                   16'h0000);
    checkOutput("plus1_0001",   pc_plus1,             16'h0001);
    applyStimulus(1'b1, 16'h3000, 1'b0, 1'b0, 16'h0000);
    stepClock(1);
    checkOutput("ld_3000",      PC,                   16'h3000);

    // Ready in IDLE is ignored.
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'hDEAD);
    stepClock(1);
    checkOutput("idle_rdy_ir",   IR,                  16'h0000);
    checkOutput("idle_rdy_done", {15'd0, fetch_done}, 16'd0);

    // Fetch with ready on the fourth request cycle.
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    stepClock(1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    checkOutput("f1_addr",      mem_bus.mem_addr,     16'h3000);
    checkOutput("f1_req_c1",    {15'd0, mem_bus.mem_req}, 16'd1);
    checkOutput("f1_busy_c1",   {15'd0, fetch_busy},  16'd1);
    stepClock(1);
    checkOutput("f1_busy_c2",   {15'd0, fetch_busy},  16'd1);
    stepClock(1);
    checkOutput("f1_busy_c3",   {15'd0, fetch_busy},  16'd1);
    checkOutput("f1_done_c3",   {15'd0, fetch_done},  16'd0);
    stepClock(1);
    checkOutput("f1_busy_c4",   {15'd0, fetch_busy},  16'd1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'h1261);
    stepClock(1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    checkOutput("f1_ir",        IR,                   16'h1261);
    checkOutput("f1_done",      {15'd0, fetch_done},  16'd1);
    checkOutput("f1_busy_end",  {15'd0, fetch_busy},  16'd0);
    checkOutput("f1_req_end",   {15'd0, mem_bus.mem_req}, 16'd0);
    stepClock(1);
    checkOutput("f1_done_once", {15'd0, fetch_done},  16'd0);

    // fetch_start together with LD_PC: address uses old PC; LD_PC mid-request leaves address alone.
    applyStimulus(1'b1, 16'h4000, 1'b1, 1'b0, 16'h0000);
    stepClock(1);
    checkOutput("coll_addr",    mem_bus.mem_addr,     16'h3000);
    checkOutput("coll_pc",      PC,                   16'h4000);
    applyStimulus(1'b1, 16'h5000, 1'b0, 1'b0, 16'h0000);
    stepClock(1);
    checkOutput("req_ld_pc",    PC,                   16'h5000);
    checkOutput("req_ld_addr",  mem_bus.mem_addr,     16'h3000);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'hABCD);
    stepClock(1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    checkOutput("coll_ir",      IR,                   16'hABCD);
    checkOutput("coll_done",    {15'd0, fetch_done},  16'd1);

    // No ready at all: error after 15 request cycles.
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    stepClock(1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    checkOutput("to_addr",      mem_bus.mem_addr,     16'h5000);
    stepClock(14);
    checkOutput("to_busy_c15",  {15'd0, fetch_busy},  16'd1);
    checkOutput("to_err_c15",   {15'd0, timeout_err}, 16'd0);
    stepClock(1);
    checkOutput("to_err",       {15'd0, timeout_err}, 16'd1);
    checkOutput("to_req_off",   {15'd0, mem_bus.mem_req}, 16'd0);
    checkOutput("to_busy_off",  {15'd0, fetch_busy},  16'd0);
    checkOutput("to_ir_kept",   IR,                   16'hABCD);
    stepClock(3);
    checkOutput("to_err_sticky", {15'd0, timeout_err}, 16'd1);
    checkOutput("to_ir_sticky", IR,                   16'hABCD);

    // Retry out of ERR clears the flag and completes.
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    stepClock(1);
    checkOutput("retry_err_clr", {15'd0, timeout_err}, 16'd0);
    checkOutput("retry_req",    {15'd0, mem_bus.mem_req}, 16'd1);
    checkOutput("retry_addr",   mem_bus.mem_addr,     16'h5000);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'h5A5A);
    stepClock(1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    checkOutput("retry_ir",     IR,                   16'h5A5A);
    checkOutput("retry_done",   {15'd0, fetch_done},  16'd1);

    // Ready on the 15th cycle wins; repeated fetch_start in REQ is ignored.
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    stepClock(2);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    stepClock(13);
    checkOutput("late_busy_c15", {15'd0, fetch_busy}, 16'd1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0F0F);
    stepClock(1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    checkOutput("late_ir",      IR,                   16'h0F0F);
    checkOutput("late_no_err",  {15'd0, timeout_err}, 16'd0);
    checkOutput("late_done",    {15'd0, fetch_done},  16'd1);
    stepClock(1);
    checkOutput("late_done_off", {15'd0, fetch_done}, 16'd0);
    checkOutput("late_idle",    {15'd0, fetch_busy},  16'd0);
    stepClock(3);
    checkOutput("late_no_refetch", {15'd0, fetch_busy}, 16'd0);

    // Reset in the middle of a request aborts without capturing.
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    stepClock(1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'h7777);
    #2 Reset_n = 1'b0;
    #1;
    checkOutput("abort_req",    {15'd0, mem_bus.mem_req}, 16'd0);
    checkOutput("abort_pc",     PC,                   16'h3000);
    checkOutput("abort_ir",     IR,                   16'h0000);
    stepClock(1);
    checkOutput("abort_ir_hold", IR,                  16'h0000);
    checkOutput("abort_done",   {15'd0, fetch_done},  16'd0);
    Reset_n = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    stepClock(1);
    checkOutput("abort_idle",   {15'd0, fetch_busy},  16'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
